// File: rtl/xgmii_tx_arbiter_if.sv
// xgmii_tx_arbiter_if: bundle of per-requester FWFT FIFO heads, flags, enables and pop strobes.
interface xgmii_tx_arbiter_if #(
    parameter int NPORTS = 3
);
    logic [NPORTS-1:0]    port_en;
    logic [72*NPORTS-1:0] req_dout;
    logic [NPORTS-1:0]    req_empty;
    logic [NPORTS-1:0]    req_rd_en;
    modport master (output port_en, req_dout, req_empty, input req_rd_en);
    modport slave (input port_en, req_dout, req_empty, output req_rd_en);
endinterface

// File: rtl/xgmii_tx_arbiter.sv
// xgmii_tx_arbiter: round-robin whole-frame egress scheduler for one XGMII TX port,
// with minimum inter-frame gap and underrun recovery (ERR word, then drain to terminate).
module xgmii_tx_arbiter #(
    parameter int NPORTS    = 3,
    parameter int IFG_WORDS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    xgmii_tx_arbiter_if.slave    req,
    output logic [63:0]          xgmii_txd,
    output logic [7:0]           xgmii_txc,
    output logic [NPORTS-1:0]    grant,
    output logic                 busy,
    output logic [31:0]          frame_cnt,
    output logic [15:0]          underrun_cnt
);
    localparam int PW = $clog2(NPORTS);
    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [63:0] ERR_D  = 64'h070707070707FDFE;
    typedef enum logic [1:0] {S_IDLE, S_XMIT, S_DRAIN, S_IFG} state_t;
    state_t            state_q, state_d;
    logic [PW-1:0]     last_q, last_d, owner_q, owner_d, cand;
    logic              found;
    logic [3:0]        ifg_q, ifg_d;
    logic [63:0]       txd_q, txd_d;
    logic [7:0]        txc_q, txc_d;
    logic [31:0]       frame_q, frame_d;
    logic [15:0]       underrun_q, underrun_d;
    logic [NPORTS-1:0] rd_en;
    logic [71:0]       cand_w, own_w;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NPORTS);
    endfunction

    function automatic logic is_term(input logic [71:0] w);
        is_term = 1'b0;
        for (int i = 0; i < 8; i++)
            if (w[64+i] && w[8*i +: 8] == 8'hFD) is_term = 1'b1;
    endfunction

    // Scan from farthest to nearest so the first eligible port after last_q wins.
    always_comb begin
        found = 1'b0;
        cand  = last_q;
        for (int k = NPORTS; k >= 1; k--)
            if (req.port_en[wrap(int'(last_q) + k)] && !req.req_empty[wrap(int'(last_q) + k)]) begin
                found = 1'b1;
                cand  = wrap(int'(last_q) + k);
            end
    end

    assign cand_w = req.req_dout[72*cand +: 72];
    assign own_w  = req.req_dout[72*owner_q +: 72];

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        ifg_d      = ifg_q;
        txd_d      = IDLE_D;
        txc_d      = 8'hFF;
        frame_d    = frame_q;
        underrun_d = underrun_q;
        rd_en      = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    rd_en[cand] = 1'b1;
                    if (cand_w[64] && cand_w[7:0] == 8'hFB) begin
                        {txc_d, txd_d} = cand_w;
                        owner_d = cand;
                        last_d  = cand;
                        state_d = S_XMIT;
                    end
                end
            end
            S_XMIT: begin
                if (!req.req_empty[owner_q]) begin
                    rd_en[owner_q] = 1'b1;
                    {txc_d, txd_d} = own_w;
                    if (is_term(own_w)) begin
                        frame_d = frame_q + 32'd1;
                        ifg_d   = 4'(IFG_WORDS - 1);
                        state_d = S_IFG;
                    end
                end else begin
                    txd_d      = ERR_D;
                    underrun_d = underrun_q + 16'(underrun_q != 16'hFFFF);
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!req.req_empty[owner_q]) begin
                    rd_en[owner_q] = 1'b1;
                    if (is_term(own_w)) begin
                        ifg_d   = 4'(IFG_WORDS - 1);
                        state_d = S_IFG;
                    end
                end
            end
            default: begin
                state_d = (ifg_q == 4'd0) ? S_IDLE : S_IFG;
                ifg_d   = (ifg_q == 4'd0) ? ifg_q : ifg_q - 4'd1;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q    <= S_IDLE;
            last_q     <= PW'(NPORTS - 1);
            owner_q    <= '0;
            ifg_q      <= '0;
            txd_q      <= IDLE_D;
            txc_q      <= 8'hFF;
            frame_q    <= '0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            ifg_q      <= ifg_d;
            txd_q      <= txd_d;
            txc_q      <= txc_d;
            frame_q    <= frame_d;
            underrun_q <= underrun_d;
        end
    end

    // Pops are suppressed while reset is held so FIFO contents survive a reset.
    assign req.req_rd_en = sys_rst ? rd_en : '0;
    assign busy          = (state_q == S_XMIT) || (state_q == S_DRAIN);
    assign grant         = busy ? NPORTS'(1) << owner_q : '0;
    assign xgmii_txd     = txd_q;
    assign xgmii_txc     = txc_q;
    assign frame_cnt     = frame_q;
    assign underrun_cnt  = underrun_q;
endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// tb_xgmii_tx_arbiter: random-frame scoreboard bench; two DUTs (IFG 1 and 3) fed by queue FIFO models.
`timescale 1ns/1ps
module tb_xgmii_tx_arbiter;
    localparam int N = 3;
    localparam logic [71:0] IDLE72 = {8'hFF, 64'h0707070707070707};
    localparam logic [71:0] ERR72  = {8'hFF, 64'h070707070707FDFE};
    typedef struct {
        logic [71:0]  w;
        int           gap;
        logic [N-1:0] g;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    xgmii_tx_arbiter_if #(.NPORTS(N)) ifa ();
    xgmii_tx_arbiter_if #(.NPORTS(N)) ifb ();
    logic [1:0][63:0]  txd;
    logic [1:0][7:0]   txc;
    logic [1:0][N-1:0] gnt, rd, emp, pen;
    logic [1:0]        busy;
    logic [1:0][31:0]  fc;
    logic [1:0][15:0]  uc;

    logic [71:0] fq [2][N][$];
    logic [71:0] stg [N][$];
    exp_t        exp_q [2][$];
    int          idles [2];
    int          mlast [2];
    int          exp_fc [2];
    int          exp_uc [2];
    int          chk = 0;
    int          errs = 0;

    xgmii_tx_arbiter #(.NPORTS(N), .IFG_WORDS(1)) u_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .req(ifa),
        .xgmii_txd(txd[0]), .xgmii_txc(txc[0]), .grant(gnt[0]), .busy(busy[0]),
        .frame_cnt(fc[0]), .underrun_cnt(uc[0])
    );
    xgmii_tx_arbiter #(.NPORTS(N), .IFG_WORDS(3)) u_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .req(ifb),
        .xgmii_txd(txd[1]), .xgmii_txc(txc[1]), .grant(gnt[1]), .busy(busy[1]),
        .frame_cnt(fc[1]), .underrun_cnt(uc[1])
    );

    assign rd  = {ifb.req_rd_en, ifa.req_rd_en};
    assign emp = {ifb.req_empty, ifa.req_empty};

    always #5 sys_clk = ~sys_clk;

    function automatic void check(string nm, logic [71:0] act, logic [71:0] expv);
        chk++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endfunction

    function automatic logic is_term(logic [71:0] w);
        for (int i = 0; i < 8; i++)
            if (w[64+i] && w[8*i +: 8] == 8'hFD) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [71:0] w_data();
        return {8'h00, $urandom(), $urandom()};
    endfunction

    function automatic logic [71:0] w_start();
        logic [71:0] w = {8'h01, $urandom(), $urandom()};
        w[7:0] = 8'hFB;
        return w;
    endfunction

    function automatic logic [71:0] w_term();
        logic [71:0] w = w_data();
        int t = $urandom_range(7, 0);
        for (int i = 0; i < 8; i++)
            if (i == t) begin
                w[8*i +: 8] = 8'hFD;
                w[64+i] = 1'b1;
            end else if (i > t) begin
                w[8*i +: 8] = 8'h07;
                w[64+i] = 1'b1;
            end
        return w;
    endfunction

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            ifa.req_dout[72*p +: 72] = fq[0][p].size() != 0 ? fq[0][p][0] : 72'h0;
            ifb.req_dout[72*p +: 72] = fq[1][p].size() != 0 ? fq[1][p][0] : 72'h0;
            ifa.req_empty[p] = fq[0][p].size() == 0;
            ifb.req_empty[p] = fq[1][p].size() == 0;
        end
        ifa.port_en = pen[0];
        ifb.port_en = pen[1];
    endtask

    task automatic tick();
        logic [1:0][N-1:0] pd;
        @(negedge sys_clk);
        pd = rd;
        @(posedge sys_clk);
        #1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < N; p++)
                if (pd[d][p] && fq[d][p].size() != 0) void'(fq[d][p].pop_front());
        drive();
    endtask

    task automatic push_word(logic [1:0] dm, int p, logic [71:0] w);
        stg[p].push_back(w);
        for (int d = 0; d < 2; d++)
            if (dm[d]) fq[d][p].push_back(w);
    endtask

    task automatic push_frame(logic [1:0] dm, int p, int len);
        push_word(dm, p, w_start());
        for (int i = 0; i < len - 2; i++) push_word(dm, p, w_data());
        push_word(dm, p, w_term());
    endtask

    task automatic expect_word(int d, logic [71:0] w, int gap, logic [N-1:0] g);
        exp_t e;
        e.w = w;
        e.gap = gap;
        e.g = g;
        exp_q[d].push_back(e);
    endtask

    // Reference: whole preloaded frames leave in round-robin order, back to back with ifg idles.
    task automatic sched(int d, int ifg);
        logic [71:0] pw [N][$];
        logic [71:0] w;
        int p;
        bit found;
        bit first = 1'b1;
        for (int q = 0; q < N; q++) pw[q] = stg[q];
        forever begin
            found = 1'b0;
            p = 0;
            for (int k = 1; k <= N; k++)
                if (!found && pw[(mlast[d] + k) % N].size() != 0) begin
                    p = (mlast[d] + k) % N;
                    found = 1'b1;
                end
            if (!found) break;
            mlast[d] = p;
            for (int i = 0; pw[p].size() != 0; i++) begin
                w = pw[p].pop_front();
                expect_word(d, w, i != 0 ? 0 : (first ? -1 : ifg), is_term(w) ? '0 : N'(1) << p);
                if (is_term(w)) break;
            end
            first = 1'b0;
            exp_fc[d]++;
        end
    endtask

    task automatic clear_stg();
        for (int p = 0; p < N; p++) stg[p].delete();
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && busy == 2'b00) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("done_timeout", {71'd0, ~ok}, 72'd0);
        repeat (4) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("frame_cnt%0d", d), {40'd0, fc[d]}, 72'(exp_fc[d]));
            check($sformatf("grant_idle%0d", d), 72'(gnt[d]), 72'd0);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b0;
        repeat (2) tick();
        sys_rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mlast[d] = N - 1;
            exp_fc[d] = 0;
            exp_uc[d] = 0;
        end
    endtask

    // Frame on DUT a port p runs dry after start + n data words, then is completed and must be discarded.
    task automatic underrun(int p, int n);
        bit ok = 1'b0;
        logic [71:0] w;
        w = w_start();
        fq[0][p].push_back(w);
        expect_word(0, w, -1, N'(1) << p);
        for (int i = 0; i < n; i++) begin
            w = w_data();
            fq[0][p].push_back(w);
            expect_word(0, w, 0, N'(1) << p);
        end
        expect_word(0, ERR72, 0, N'(1) << p);
        exp_uc[0] = exp_uc[0] < 16'hFFFF ? exp_uc[0] + 1 : exp_uc[0];
        drive();
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            ok = exp_q[0].size() == 0;
        end
        check("err_timeout", {71'd0, ~ok}, 72'd0);
        check("busy_drain", {71'd0, busy[0]}, 72'd1);
        check("underrun_cnt", {56'd0, uc[0]}, 72'(exp_uc[0]));
        fq[0][p].push_back(w_data());
        fq[0][p].push_back(w_start());
        fq[0][p].push_back(w_term());
        drive();
        wait_done();
        check("drained", 72'(fq[0][p].size()), 72'd0);
        check("underrun_cnt_after", {56'd0, uc[0]}, 72'(exp_uc[0]));
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("protocol%0d", d), {71'd0, !$onehot0(rd[d]) || |(rd[d] & emp[d])}, 72'd0);
            if ({txc[d], txd[d]} === IDLE72) idles[d]++;
            else begin
                if (exp_q[d].size() == 0) check($sformatf("unexpected%0d", d), {txc[d], txd[d]}, IDLE72);
                else begin
                    e = exp_q[d].pop_front();
                    check($sformatf("word%0d", d), {txc[d], txd[d]}, e.w);
                    check($sformatf("grant%0d", d), 72'(gnt[d]), 72'(e.g));
                    if (e.gap >= 0) check($sformatf("gap%0d", d), 72'(idles[d]), 72'(e.gap));
                end
                idles[d] = 0;
            end
        end
    end

    initial begin
        bit ok;
        pen = '1;
        idles[0] = 0;
        idles[1] = 0;
        drive();
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_xgmii%0d", d), {txc[d], txd[d]}, IDLE72);
            check($sformatf("rst_grant%0d", d), 72'(gnt[d]), 72'd0);
            check($sformatf("rst_busy%0d", d), 72'(busy[d]), 72'd0);
            check($sformatf("rst_fc%0d", d), 72'(fc[d]), 72'd0);
            check($sformatf("rst_uc%0d", d), 72'(uc[d]), 72'd0);
            check($sformatf("rst_rd%0d", d), 72'(rd[d]), 72'd0);
        end
        do_reset();

        push_frame(2'b01, 0, 9);
        sched(0, 1);
        clear_stg();
        drive();
        wait_done();

        do_reset();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < N; p++) push_frame(2'b11, p, $urandom_range(10, 2));
        sched(0, 1);
        sched(1, 3);
        clear_stg();
        drive();
        wait_done();

        underrun(1, 3);

        pen[0] = 3'b110;
        push_frame(2'b01, 0, 10);
        fq[0][2].push_back(w_data());
        drive();
        repeat (20) tick();
        check("orphan_popped", 72'(fq[0][2].size()), 72'd0);
        check("disabled_untouched", 72'(fq[0][0].size()), 72'd10);
        check("disabled_busy", 72'(busy[0]), 72'd0);
        pen[0] = 3'b111;
        sched(0, 1);
        clear_stg();
        drive();
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            ok = exp_q[0].size() <= 6;
        end
        check("midframe_timeout", {71'd0, ~ok}, 72'd0);
        pen[0] = 3'b110;
        drive();
        wait_done();
        pen[0] = 3'b111;
        drive();

        force u_a.underrun_q = 16'hFFFE;
        tick();
        release u_a.underrun_q;
        tick();
        exp_uc[0] = 16'hFFFE;
        check("uc_preset", {56'd0, uc[0]}, 72'hFFFE);
        underrun(1, 1);
        underrun(2, 2);

        push_frame(2'b01, 0, 8);
        sched(0, 1);
        clear_stg();
        drive();
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            ok = fq[0][0].size() == 5;
        end
        check("word3_timeout", {71'd0, ~ok}, 72'd0);
        sys_rst = 1'b0;
        tick();
        exp_q[0].delete();
        check("mrst_xgmii", {txc[0], txd[0]}, IDLE72);
        check("mrst_rd", 72'(rd[0]), 72'd0);
        check("mrst_fc", 72'(fc[0]), 72'd0);
        check("mrst_uc", 72'(uc[0]), 72'd0);
        check("mrst_grant", 72'(gnt[0]), 72'd0);
        check("mrst_fifo", 72'(fq[0][0].size()), 72'd5);
        fq[0][0].delete();
        sys_rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mlast[d] = N - 1;
            exp_fc[d] = 0;
            exp_uc[d] = 0;
        end
        push_frame(2'b01, 1, 5);
        push_frame(2'b01, 0, 4);
        sched(0, 1);
        clear_stg();
        drive();
        wait_done();

        $display("Result: errors=%0d of %0d checks", errs, chk);
        $finish;
    end
endmodule
